// File: rtl/fetch_pipe_ctrl.sv
// Instruction fetch stage controller: PC sequencing, IF/ID register, HLT detection
// and a saturating count of cycles where a fetch request was not served.
module fetch_pipe_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_decode,
    input  logic        flush,
    input  logic [15:0] branch_target,
    input  logic [15:0] imem_rdata,
    input  logic        imem_ready,
    output logic [15:0] pc,
    output logic        imem_req,
    output logic [15:0] fd_instr,
    output logic [15:0] fd_pc_plus2,
    output logic        fd_valid,
    output logic        halted,
    output logic [15:0] fetch_miss_cnt
);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_HALT  = 1'b1
    } state_t;

    localparam logic [3:0] HLT_OP = 4'b1111;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_pc;
    logic [15:0] r_fd_instr;
    logic [15:0] r_fd_pc_plus2;
    logic        r_fd_valid;
    logic [15:0] r_miss_cnt;

    logic [15:0] w_pc_nxt;
    logic [15:0] w_fd_instr_nxt;
    logic [15:0] w_fd_pc_plus2_nxt;
    logic        w_fd_valid_nxt;
    logic [15:0] w_miss_cnt_nxt;
    logic [15:0] w_pc_plus2;
    logic        w_is_hlt;
    logic        w_req;
    logic        w_miss;

    // Request is suppressed while reset is held so nothing is fetched before release.
    assign w_req      = rst_n && (r_state == S_FETCH) && !stall_decode;
    assign w_miss     = w_req && !imem_ready;
    assign w_pc_plus2 = r_pc + 16'd2;
    assign w_is_hlt   = (imem_rdata[15:12] == HLT_OP);

    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_fd_instr_nxt    = r_fd_instr;
        w_fd_pc_plus2_nxt = r_fd_pc_plus2;
        w_fd_valid_nxt    = r_fd_valid;
        w_miss_cnt_nxt    = w_miss ? sat_inc(r_miss_cnt) : r_miss_cnt;

        if (flush) begin
            w_pc_nxt       = branch_target;
            w_fd_valid_nxt = 1'b0;
            w_fd_instr_nxt = 16'h0000;
            w_state_nxt    = S_FETCH;
        end else if (stall_decode) begin
            w_state_nxt = r_state;
        end else if (r_state == S_HALT) begin
            // HLT already sits in (or has left) IF/ID; keep feeding bubbles.
            w_fd_valid_nxt = 1'b0;
            w_fd_instr_nxt = 16'h0000;
        end else if (imem_ready) begin
            w_fd_instr_nxt    = imem_rdata;
            w_fd_pc_plus2_nxt = w_pc_plus2;
            w_fd_valid_nxt    = 1'b1;
            if (w_is_hlt) begin
                w_state_nxt = S_HALT;
            end else begin
                w_pc_nxt = w_pc_plus2;
            end
        end else begin
            w_fd_valid_nxt = 1'b0;
            w_fd_instr_nxt = 16'h0000;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_FETCH;
            r_pc          <= 16'h0000;
            r_fd_instr    <= 16'h0000;
            r_fd_pc_plus2 <= 16'h0000;
            r_fd_valid    <= 1'b0;
            r_miss_cnt    <= 16'h0000;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_fd_instr    <= w_fd_instr_nxt;
            r_fd_pc_plus2 <= w_fd_pc_plus2_nxt;
            r_fd_valid    <= w_fd_valid_nxt;
            r_miss_cnt    <= w_miss_cnt_nxt;
        end
    end

    assign pc             = r_pc;
    assign imem_req       = w_req;
    assign fd_instr       = r_fd_instr;
    assign fd_pc_plus2    = r_fd_pc_plus2;
    assign fd_valid       = r_fd_valid;
    assign halted         = (r_state == S_HALT);
    assign fetch_miss_cnt = r_miss_cnt;

endmodule

// File: tb/tb_fetch_pipe_ctrl.sv
// Bench for fetch_pipe_ctrl: directed vectors, a behavioural reference model
// checked every cycle, and hand-computed literal expectations.
module tb_fetch_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_decode;
    logic        flush;
    logic [15:0] branch_target;
    logic [15:0] imem_rdata;
    logic        imem_ready;
    logic [15:0] pc;
    logic        imem_req;
    logic [15:0] fd_instr;
    logic [15:0] fd_pc_plus2;
    logic        fd_valid;
    logic        halted;
    logic [15:0] fetch_miss_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    fetch_pipe_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall_decode   (stall_decode),
        .flush          (flush),
        .branch_target  (branch_target),
        .imem_rdata     (imem_rdata),
        .imem_ready     (imem_ready),
        .pc             (pc),
        .imem_req       (imem_req),
        .fd_instr       (fd_instr),
        .fd_pc_plus2    (fd_pc_plus2),
        .fd_valid       (fd_valid),
        .halted         (halted),
        .fetch_miss_cnt (fetch_miss_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: what the fetch stage must hold after each edge.
    logic [15:0] m_pc     = 16'h0000;
    logic [15:0] m_instr  = 16'h0000;
    logic [15:0] m_pp2    = 16'h0000;
    logic        m_valid  = 1'b0;
    logic        m_halted = 1'b0;
    logic [15:0] m_cnt    = 16'h0000;
    logic        m_req;

    assign m_req = rst_n && !m_halted && !stall_decode;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc     <= 16'h0000;
            m_instr  <= 16'h0000;
            m_pp2    <= 16'h0000;
            m_valid  <= 1'b0;
            m_halted <= 1'b0;
            m_cnt    <= 16'h0000;
        end else begin
            if (m_req && !imem_ready && m_cnt != 16'hFFFF)
                m_cnt <= m_cnt + 16'd1;
            if (flush) begin
                m_pc     <= branch_target;
                m_valid  <= 1'b0;
                m_instr  <= 16'h0000;
                m_halted <= 1'b0;
            end else if (stall_decode) begin
                m_pc <= m_pc;
            end else if (m_halted) begin
                m_valid <= 1'b0;
                m_instr <= 16'h0000;
            end else if (imem_ready) begin
                m_instr <= imem_rdata;
                m_pp2   <= 16'(m_pc + 16'd2);
                m_valid <= 1'b1;
                if (imem_rdata[15:12] == 4'hF) m_halted <= 1'b1;
                else                            m_pc     <= 16'(m_pc + 16'd2);
            end else begin
                m_valid <= 1'b0;
                m_instr <= 16'h0000;
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        chk("model_pc",       pc,                   m_pc);
        chk("model_imem_req", 16'(imem_req),        16'(m_req));
        chk("model_fd_instr", fd_instr,             m_instr);
        chk("model_fd_pp2",   fd_pc_plus2,          m_pp2);
        chk("model_fd_valid", 16'(fd_valid),        16'(m_valid));
        chk("model_halted",   16'(halted),          16'(m_halted));
        chk("model_miss_cnt", fetch_miss_cnt,       m_cnt);
    end

    task automatic drive(input logic s, input logic f, input logic [15:0] t,
                         input logic [15:0] d, input logic r);
        stall_decode  = s;
        flush         = f;
        branch_target = t;
        imem_rdata    = d;
        imem_ready    = r;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        stall_decode = 1'b0; flush = 1'b0; branch_target = 16'h0;
        imem_rdata = 16'h0; imem_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_pc",       pc,             16'h0000);
        chk("rst_req",      16'(imem_req),  16'h0000);
        chk("rst_valid",    16'(fd_valid),  16'h0000);
        chk("rst_halted",   16'(halted),    16'h0000);
        chk("rst_cnt",      fetch_miss_cnt, 16'h0000);
        rst_n = 1'b1;

        // Two straight-line fetches
        drive(0, 0, 16'h0, 16'h1234, 1);
        chk("f1_instr", fd_instr, 16'h1234);
        chk("f1_pp2",   fd_pc_plus2, 16'h0002);
        chk("f1_pc",    pc, 16'h0002);
        drive(0, 0, 16'h0, 16'h5678, 1);
        chk("f2_instr", fd_instr, 16'h5678);
        chk("f2_pc",    pc, 16'h0004);

        // Three stalled cycles at pc=4, one with imem not ready
        drive(1, 0, 16'h0, 16'h9999, 1);
        drive(1, 0, 16'h0, 16'h0000, 0);
        drive(1, 0, 16'h0, 16'h9999, 1);
        chk("stall_req",   16'(imem_req), 16'h0000);
        chk("stall_pc",    pc, 16'h0004);
        chk("stall_instr", fd_instr, 16'h5678);
        chk("stall_cnt",   fetch_miss_cnt, 16'h0000);

        // Advance to pc=8, then two misses
        drive(0, 0, 16'h0, 16'h2222, 1);
        drive(0, 0, 16'h0, 16'h3333, 1);
        chk("pre_miss_pc", pc, 16'h0008);
        drive(0, 0, 16'h0, 16'h0000, 0);
        chk("miss1_valid", 16'(fd_valid), 16'h0000);
        drive(0, 0, 16'h0, 16'h0000, 0);
        chk("miss2_valid", 16'(fd_valid), 16'h0000);
        chk("miss2_cnt",   fetch_miss_cnt, 16'h0002);
        chk("miss2_pc",    pc, 16'h0008);
        drive(0, 0, 16'h0, 16'h4444, 1);
        chk("after_miss_pp2", fd_pc_plus2, 16'h000A);

        // Flush wins over a simultaneous stall
        drive(1, 1, 16'h0040, 16'h0000, 1);
        chk("flush_pc",    pc, 16'h0040);
        chk("flush_valid", 16'(fd_valid), 16'h0000);
        chk("flush_cnt",   fetch_miss_cnt, 16'h0002);

        // HLT at 0x0010
        drive(0, 1, 16'h0010, 16'h0000, 1);
        drive(0, 0, 16'h0, 16'hF000, 1);
        chk("hlt_instr",  fd_instr, 16'hF000);
        chk("hlt_halted", 16'(halted), 16'h0001);
        chk("hlt_pc",     pc, 16'h0010);
        chk("hlt_req",    16'(imem_req), 16'h0000);
        drive(0, 0, 16'h0, 16'h0000, 0);
        chk("hlt_bubble", 16'(fd_valid), 16'h0000);
        chk("hlt_cnt",    fetch_miss_cnt, 16'h0002);
        drive(0, 1, 16'h0020, 16'h0000, 0);
        chk("unhalt_halted", 16'(halted), 16'h0000);
        chk("unhalt_pc",     pc, 16'h0020);

        // PC wrap
        drive(0, 1, 16'hFFFE, 16'h0000, 1);
        drive(0, 0, 16'h0, 16'h1000, 1);
        chk("wrap_pc",  pc, 16'h0000);
        chk("wrap_pp2", fd_pc_plus2, 16'h0000);

        // Asynchronous reset in the middle of a miss
        stall_decode = 1'b0; flush = 1'b0; imem_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("amiss_pc",  pc, 16'h0000);
        chk("amiss_cnt", fetch_miss_cnt, 16'h0000);
        chk("amiss_req", 16'(imem_req), 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 16'h0, 16'hABCD, 1);
        chk("rel_instr", fd_instr, 16'hABCD);
        chk("rel_pp2",   fd_pc_plus2, 16'h0002);

        // Asynchronous reset while halted
        drive(0, 0, 16'h0, 16'hF123, 1);
        chk("h2_halted", 16'(halted), 16'h0001);
        #2 rst_n = 1'b0;
        #1;
        chk("ahalt_halted", 16'(halted), 16'h0000);
        chk("ahalt_valid",  16'(fd_valid), 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Saturate the miss counter, then confirm flush leaves it alone
        repeat (65535) drive(0, 0, 16'h0, 16'h0000, 0);
        chk("sat_reach", fetch_miss_cnt, 16'hFFFF);
        drive(0, 0, 16'h0, 16'h0000, 0);
        chk("sat_hold", fetch_miss_cnt, 16'hFFFF);
        drive(0, 1, 16'h0050, 16'h0000, 0);
        chk("sat_flush_cnt", fetch_miss_cnt, 16'hFFFF);
        chk("sat_flush_pc",  pc, 16'h0050);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
